// File: rtl/glip_tx_arbiter_if.sv
// glip_tx_arbiter_if: requester streams in, GLIP burst stream out, plus grant/busy status
interface glip_tx_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NCH = 4
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [GW-1:0] grant;
  logic busy;
  modport master (
    input in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant, busy
  );
  modport slave (
    output in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, grant, busy
  );
endinterface

// File: rtl/glip_tx_arbiter.sv
// glip_tx_arbiter: round-robin burst arbiter; clk_logic/rst plus bus (in_* requester streams, out_* header+data toward GLIP fifo_out, grant, busy)
module glip_tx_arbiter #(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk_logic,
  input logic rst,
  glip_tx_arbiter_if.master bus
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int AW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, HEADER, DRAIN} state_t;
  state_t state_q;
  logic [GW-1:0] ptr_q, grant_q, grant_d, grant_nx;
  logic [CW-1:0] count_q, rd_q;
  logic [WIDTH-1:0] out_data_q, word, hdr;
  logic out_valid_q;
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [NCH-1:0] rot;
  logic [GW:0] sum;
  int off;
  always_comb begin
    rot = NCH'({bus.in_valid, bus.in_valid} >> ptr_q);
    off = 0;
    for (int i = NCH - 1; i >= 0; i--) if (rot[i]) off = i;
    sum = (GW+1)'(ptr_q) + (GW+1)'(off);
    grant_d = sum >= (GW+1)'(NCH) ? GW'(sum - (GW+1)'(NCH)) : GW'(sum);
  end
  assign grant_nx = grant_q == GW'(NCH - 1) ? '0 : grant_q + 1'b1;
  assign word = bus.in_data[grant_q*WIDTH +: WIDTH];
  assign hdr = WIDTH'({8'(grant_q), 8'(count_q)});
  assign bus.in_ready = (state_q == COLLECT && count_q < CW'(MAX_BURST)) ? NCH'(1) << grant_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.grant = grant_q;
  assign bus.busy = state_q != IDLE;
  always_ff @(posedge clk_logic) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      count_q <= '0;
      rd_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.in_valid) begin
          grant_q <= grant_d;
          state_q <= COLLECT;
        end
        COLLECT: if (count_q == CW'(MAX_BURST) || (!bus.in_valid[grant_q] && count_q != '0)) begin
          state_q <= HEADER;
          out_valid_q <= 1'b1;
          out_data_q <= hdr;
        end else if (bus.in_valid[grant_q]) begin
          mem_q[AW'(count_q)] <= word;
          count_q <= count_q + 1'b1;
        end else begin
          state_q <= IDLE;
          ptr_q <= grant_nx;
        end
        HEADER: if (bus.out_ready) begin
          state_q <= DRAIN;
          rd_q <= '0;
          out_data_q <= mem_q[0];
        end
        DRAIN: if (bus.out_ready) begin
          if (rd_q == count_q - 1'b1) begin
            state_q <= IDLE;
            out_valid_q <= 1'b0;
            ptr_q <= grant_nx;
            count_q <= '0;
          end else begin
            rd_q <= rd_q + 1'b1;
            out_data_q <= mem_q[AW'(rd_q + 1'b1)];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glip_tx_arbiter.sv
// tb_glip_tx_arbiter: vector table, corner sequences and random traffic against a transaction-level model
module tb_glip_tx_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int MB = 8;
  typedef struct {
    int ch;
    int n;
    logic [15:0] base;
    logic [15:0] hdr0;
    logic [15:0] hdr1;
  } vec_t;
  logic clk_logic = 1'b0;
  logic rst = 1'b1;
  always #5 clk_logic = ~clk_logic;
  glip_tx_arbiter_if #(.WIDTH(W), .NCH(N)) bus ();
  glip_tx_arbiter #(.WIDTH(W), .NCH(N), .MAX_BURST(MB)) dut (
    .clk_logic(clk_logic),
    .rst(rst),
    .bus(bus)
  );
  vec_t vt[5];
  logic [15:0] src_q[N][$];
  logic [15:0] acc_q[N][$];
  logic [15:0] out_log[$];
  logic [15:0] exp_q[$];
  int out_t[$];
  bit en[N];
  bit pop[N];
  int seq[N];
  int or_mode, cyc, errs, checks, hdr_cnt;
  int m_phase, m_g, m_ptr, m_acc, m_left;
  bit st_prev;
  logic [15:0] st_data;
  logic [N-1:0] rdy_seen;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ptr = 0;
    m_g = 0;
    m_acc = 0;
    m_left = 0;
    st_prev = 0;
    for (int c = 0; c < N; c++) acc_q[c].delete();
  endtask

  // phase: 0 idle, 1 first cycle after grant, 2 collecting, 3 sending the burst
  task automatic monitor();
    cyc++;
    for (int c = 0; c < N; c++) pop[c] = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (st_prev) begin
      chk("stable_valid", int'(bus.out_valid), 1);
      chk("stable_data", int'(bus.out_data), int'(st_data));
    end
    st_prev = bus.out_valid && !bus.out_ready;
    st_data = bus.out_data;
    rdy_seen |= bus.in_ready;
    chk("in_ready_legal", int'((bus.in_ready & ~(N'(1) << m_g)) == 0 &&
        !((m_phase == 0 || m_phase == 3 || bus.out_valid) && bus.in_ready != 0)), 1);
    if (m_phase == 0) begin
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_out_valid", int'(bus.out_valid), 0);
      if (|bus.in_valid) begin
        m_g = rr(m_ptr, bus.in_valid);
        m_acc = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      chk("grant", int'(bus.grant), m_g);
      chk("busy", int'(bus.busy), 1);
      if (bus.in_valid[m_g]) begin
        chk("first_accept", int'(bus.in_ready[m_g]), 1);
        m_phase = 2;
      end else begin
        m_phase = 0;
        m_ptr = (m_g + 1) % N;
      end
    end
    for (int c = 0; c < N; c++)
      if (bus.in_valid[c] && bus.in_ready[c]) begin
        acc_q[c].push_back(bus.in_data[c*W +: W]);
        pop[c] = 1;
        if (c == m_g) m_acc++;
      end
    if (bus.out_valid && bus.out_ready) begin
      out_log.push_back(bus.out_data);
      out_t.push_back(cyc);
      if (m_phase == 2) begin
        chk("header", int'(bus.out_data), (m_g << 8) | m_acc);
        chk("burst_len_ok", int'(m_acc >= 1 && m_acc <= MB), 1);
        hdr_cnt++;
        m_left = m_acc;
        m_phase = 3;
      end else if (m_phase == 3) begin
        if (acc_q[m_g].size() == 0) chk("data_avail", 0, 1);
        else chk("data", int'(bus.out_data), int'(acc_q[m_g].pop_front()));
        m_left--;
        if (m_left <= 0) begin
          m_phase = 0;
          m_ptr = (m_g + 1) % N;
        end
      end else chk("unexpected_out", m_phase, 2);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (pop[c]) void'(src_q[c].pop_front());
      pop[c] = 0;
      bus.in_valid[c] = en[c] && src_q[c].size() > 0;
      bus.in_data[c*W +: W] = src_q[c].size() > 0 ? src_q[c][0] : 16'h0;
    end
    bus.out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  endtask

  task automatic cycle();
    @(negedge clk_logic);
    monitor();
    @(posedge clk_logic);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < N; c++) begin
      en[c] = 0;
      src_q[c].delete();
    end
    or_mode = 0;
    drive();
    repeat (2) cycle();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    out_log.delete();
    out_t.delete();
    rdy_seen = '0;
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < N; c++) if (src_q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(int maxc);
    int k = 0;
    while (k < maxc && !(all_empty() && m_phase == 0 && bus.in_valid == '0)) begin
      cycle();
      k++;
    end
    chk("run_done", int'(k < maxc), 1);
    cycle();
  endtask

  task automatic wait_out(int cnt, int maxc);
    int k = 0;
    while (out_log.size() < cnt && k < maxc) begin
      cycle();
      k++;
    end
    chk("wait_out", int'(out_log.size() >= cnt), 1);
  endtask

  task automatic cmp_log(string nm);
    chk({nm, "_len"}, out_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < out_log.size(); k++)
      chk({nm, "_word"}, int'(out_log[k]), int'(exp_q[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    errs = 0;
    checks = 0;
    cyc = 0;
    hdr_cnt = 0;
    rdy_seen = '0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    model_reset();
    vt[0] = '{1, 3, 16'hA001, 16'h0103, 16'h0000};
    vt[1] = '{2, 10, 16'h0000, 16'h0208, 16'h0202};
    vt[2] = '{0, 8, 16'h5000, 16'h0008, 16'h0000};
    vt[3] = '{3, 1, 16'h7777, 16'h0301, 16'h0000};
    vt[4] = '{0, 9, 16'h1230, 16'h0008, 16'h0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      out_log.delete();
      out_t.delete();
      exp_q.delete();
      for (int k = 0; k < vt[i].n; k++) src_q[vt[i].ch].push_back(16'(vt[i].base + 16'(k)));
      exp_q.push_back(vt[i].hdr0);
      for (int k = 0; k < vt[i].n && k < MB; k++) exp_q.push_back(16'(vt[i].base + 16'(k)));
      if (vt[i].n > MB) begin
        exp_q.push_back(vt[i].hdr1);
        for (int k = MB; k < vt[i].n; k++) exp_q.push_back(16'(vt[i].base + 16'(k)));
      end
      en[vt[i].ch] = 1;
      drive();
      run_until_idle(200);
      cmp_log("vec");
      chk("vec_grant", int'(bus.grant), vt[i].ch);
      chk("vec_busy", int'(bus.busy), 0);
      for (int k = 1; k <= vt[i].n && k <= MB && k < out_t.size(); k++)
        chk("vec_back2back", out_t[k] - out_t[0], k);
      en[vt[i].ch] = 0;
    end
    do_reset();
    for (int k = 0; k < 40; k++) begin
      src_q[0].push_back(16'(k));
      src_q[3].push_back(16'(16'h3000 + k));
    end
    en[0] = 1;
    en[3] = 1;
    drive();
    wait_out(36, 400);
    exp_q = '{16'h0008, 16'h0308, 16'h0008, 16'h0308};
    for (int b = 0; b < 4 && 9*b < out_log.size(); b++)
      chk("alt_header", int'(out_log[9*b]), int'(exp_q[b]));
    chk("alt_no_other_ready", int'(rdy_seen & 4'b0110), 0);
    do_reset();
    or_mode = 1;
    for (int k = 0; k < 4; k++) src_q[0].push_back(16'(16'hB000 + k));
    en[0] = 1;
    drive();
    wait_out(1, 100);
    src_q[0].push_back(16'hB004);
    src_q[0].push_back(16'hB005);
    drive();
    run_until_idle(300);
    exp_q = '{16'h0004, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'h0002, 16'hB004, 16'hB005};
    cmp_log("stall");
    do_reset();
    for (int k = 0; k < 5; k++) src_q[1].push_back(16'(16'hC000 + k));
    en[1] = 1;
    drive();
    wait_out(3, 100);
    rst = 1'b1;
    cycle();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    out_log.delete();
    src_q[1].delete();
    src_q[1].push_back(16'hC100);
    src_q[1].push_back(16'hC101);
    drive();
    run_until_idle(100);
    exp_q = '{16'h0102, 16'hC100, 16'hC101};
    cmp_log("midrst");
    do_reset();
    src_q[2].push_back(16'hD000);
    en[2] = 1;
    drive();
    cycle();
    en[2] = 0;
    drive();
    repeat (5) cycle();
    chk("spur_no_out", out_log.size(), 0);
    chk("spur_busy", int'(bus.busy), 0);
    src_q[3].push_back(16'hD300);
    en[2] = 1;
    en[3] = 1;
    drive();
    run_until_idle(100);
    exp_q = '{16'h0301, 16'hD300, 16'h0201, 16'hD000};
    cmp_log("spur");
    do_reset();
    hdr_cnt = 0;
    or_mode = 2;
    for (int c = 0; c < N; c++) seq[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0) en[c] = !en[c];
        if ($urandom_range(0, 3) == 0 && src_q[c].size() < 20) begin
          src_q[c].push_back(16'((c << 12) | seq[c]));
          seq[c]++;
        end
      end
      drive();
      cycle();
    end
    for (int c = 0; c < N; c++) en[c] = 1;
    or_mode = 0;
    drive();
    run_until_idle(2000);
    chk("rand_drained", acc_q[0].size() + acc_q[1].size() + acc_q[2].size() + acc_q[3].size(), 0);
    chk("rand_activity", int'(hdr_cnt >= 20), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
